// File: rtl/agc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : agc_sequencer
//  Purpose  : Fetch/decode/execute sequencer; emits class code and step index
//             for the downstream control-word decoder.
//  Revision : 1.0  initial release
// ============================================================================
module agc_sequencer #(
  parameter int STEP_W     = 5,
  parameter int MP_STEPS   = 8,
  parameter int DV_STEPS   = 8,
  parameter int INTR_STEPS = 4,
  parameter int IRQ_EN     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [2:0]        opcode,
  input  logic [1:0]        qc,
  input  logic              mem_ready,
  input  logic              hold,
  input  logic              irq,
  output logic              fetch_rd,
  output logic              b_load,
  output logic [3:0]        cls,
  output logic [STEP_W-1:0] step,
  output logic              step_en,
  output logic              instr_done,
  output logic              ext_flag,
  output logic              irq_ack,
  output logic              trap,
  output logic              busy
);

  localparam logic [3:0] CLS_TC      = 4'd0;
  localparam logic [3:0] CLS_CCS     = 4'd1;
  localparam logic [3:0] CLS_INDEX   = 4'd2;
  localparam logic [3:0] CLS_XCH     = 4'd3;
  localparam logic [3:0] CLS_CS      = 4'd4;
  localparam logic [3:0] CLS_TS      = 4'd5;
  localparam logic [3:0] CLS_AD      = 4'd6;
  localparam logic [3:0] CLS_MASK    = 4'd7;
  localparam logic [3:0] CLS_SU      = 4'd8;
  localparam logic [3:0] CLS_MP      = 4'd9;
  localparam logic [3:0] CLS_DV      = 4'd10;
  localparam logic [3:0] CLS_EXTEND  = 4'd11;
  localparam logic [3:0] CLS_INTR    = 4'd12;
  localparam logic [3:0] CLS_ILLEGAL = 4'd15;

  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0] INTR_LAST = STEP_W'(INTR_STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_FWAIT  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_INTR   = 3'd5
  } state_t;

  state_t            state;
  state_t            bnd_state;
  logic [STEP_W-1:0] len;
  logic [3:0]        dec_cls;
  logic [STEP_W-1:0] dec_len;
  logic              dec_illegal;
  logic              ext_next;
  logic              last_step;

  always_comb begin
    dec_cls = CLS_ILLEGAL;
    dec_len = '0;
    if (!ext_flag) begin
      case (opcode)
        3'd0: begin dec_cls = CLS_TC;   dec_len = STEP_W'(6); end
        3'd1: begin dec_cls = CLS_CCS;  dec_len = STEP_W'(8); end
        3'd4: begin dec_cls = CLS_CS;   dec_len = STEP_W'(6); end
        3'd6: begin dec_cls = CLS_AD;   dec_len = STEP_W'(7); end
        3'd7: begin dec_cls = CLS_MASK; dec_len = STEP_W'(7); end
        3'd5: begin
          case (qc)
            2'd0:    begin dec_cls = CLS_INDEX;  dec_len = STEP_W'(12); end
            2'd1:    begin dec_cls = CLS_EXTEND; dec_len = STEP_W'(4);  end
            2'd2:    begin dec_cls = CLS_TS;     dec_len = STEP_W'(5);  end
            default: begin dec_cls = CLS_XCH;    dec_len = STEP_W'(7);  end
          endcase
        end
        default: ;
      endcase
    end else begin
      case (opcode)
        3'd6: begin dec_cls = CLS_SU; dec_len = STEP_W'(7);        end
        3'd7: begin dec_cls = CLS_MP; dec_len = STEP_W'(MP_STEPS); end
        3'd1: begin dec_cls = CLS_DV; dec_len = STEP_W'(DV_STEPS); end
        3'd5: begin
          if (qc == 2'd1) begin
            dec_cls = CLS_EXTEND;
            dec_len = STEP_W'(4);
          end
        end
        default: ;
      endcase
    end
  end

  assign dec_illegal = (dec_cls == CLS_ILLEGAL);

  // Completion value of ext_flag; an illegal decode always completes with 0.
  always_comb begin
    ext_next = (state == S_EXEC) && (cls == CLS_EXTEND);
    if ((IRQ_EN != 0) && irq && !ext_next) begin
      bnd_state = S_INTR;
    end else if (run) begin
      bnd_state = S_FETCH;
    end else begin
      bnd_state = S_IDLE;
    end
  end

  assign last_step  = (step == (len - STEP_ONE));
  assign b_load     = (state == S_FWAIT) && mem_ready;
  assign step_en    = (state == S_INTR) || ((state == S_EXEC) && !hold);
  assign instr_done = (state == S_EXEC) && !hold && last_step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cls      <= '0;
      step     <= '0;
      len      <= '0;
      ext_flag <= 1'b0;
      fetch_rd <= 1'b0;
      irq_ack  <= 1'b0;
      trap     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      fetch_rd <= 1'b0;
      irq_ack  <= 1'b0;
      trap     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state    <= S_FETCH;
            fetch_rd <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_FETCH: state <= S_FWAIT;
        S_FWAIT: begin
          if (mem_ready) state <= S_DECODE;
        end
        S_DECODE: begin
          cls  <= dec_cls;
          len  <= dec_len;
          step <= '0;
          if (dec_illegal) begin
            trap     <= 1'b1;
            ext_flag <= 1'b0;
            state    <= bnd_state;
            fetch_rd <= (bnd_state == S_FETCH);
            irq_ack  <= (bnd_state == S_INTR);
            busy     <= (bnd_state != S_IDLE);
            if (bnd_state == S_INTR) cls <= CLS_INTR;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!hold) begin
            if (last_step) begin
              step     <= '0;
              ext_flag <= ext_next;
              state    <= bnd_state;
              fetch_rd <= (bnd_state == S_FETCH);
              irq_ack  <= (bnd_state == S_INTR);
              busy     <= (bnd_state != S_IDLE);
              if (bnd_state == S_INTR) cls <= CLS_INTR;
            end else begin
              step <= step + STEP_ONE;
            end
          end
        end
        S_INTR: begin
          if (step == INTR_LAST) begin
            step     <= '0;
            state    <= run ? S_FETCH : S_IDLE;
            fetch_rd <= run;
            busy     <= run;
          end else begin
            step <= step + STEP_ONE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_agc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_agc_sequencer
//  Purpose  : Directed self-checking bench for agc_sequencer (DV_STEPS = 20).
//  Revision : 1.0  initial release
// ============================================================================
module tb_agc_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic [2:0] opcode;
  logic [1:0] qc;
  logic       mem_ready;
  logic       hold;
  logic       irq;
  logic       fetch_rd;
  logic       b_load;
  logic [3:0] cls;
  logic [4:0] step;
  logic       step_en;
  logic       instr_done;
  logic       ext_flag;
  logic       irq_ack;
  logic       trap;
  logic       busy;

  int tests = 0;
  int fails = 0;

  agc_sequencer #(
    .STEP_W(5), .MP_STEPS(8), .DV_STEPS(20), .INTR_STEPS(4), .IRQ_EN(1)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .qc(qc),
    .mem_ready(mem_ready), .hold(hold), .irq(irq),
    .fetch_rd(fetch_rd), .b_load(b_load), .cls(cls), .step(step),
    .step_en(step_en), .instr_done(instr_done), .ext_flag(ext_flag),
    .irq_ack(irq_ack), .trap(trap), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, ".cls"}, 32'(cls), 0);
    chk({tag, ".step"}, 32'(step), 0);
    chk({tag, ".ext_flag"}, 32'(ext_flag), 0);
    chk({tag, ".fetch_rd"}, 32'(fetch_rd), 0);
    chk({tag, ".b_load"}, 32'(b_load), 0);
    chk({tag, ".step_en"}, 32'(step_en), 0);
    chk({tag, ".instr_done"}, 32'(instr_done), 0);
    chk({tag, ".irq_ack"}, 32'(irq_ack), 0);
    chk({tag, ".trap"}, 32'(trap), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
  endtask

  // Entered in the FETCH cycle; returns in the cycle after DECODE.
  task automatic fetch_phase(input logic [2:0] op, input logic [1:0] q, input int wait_n);
    chk("fetch.fetch_rd", 32'(fetch_rd), 1);
    chk("fetch.busy", 32'(busy), 1);
    opcode    = op;
    qc        = q;
    mem_ready = (wait_n == 0);
    tick();
    chk("fwait.fetch_rd", 32'(fetch_rd), 0);
    for (int w = 0; w < wait_n; w++) begin
      chk("fwait.b_load_low", 32'(b_load), 0);
      chk("fwait.busy", 32'(busy), 1);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("fwait.b_load", 32'(b_load), 1);
    tick();
    chk("decode.b_load", 32'(b_load), 0);
    chk("decode.step_en", 32'(step_en), 0);
    tick();
  endtask

  // Entered on step 0 of EXEC; returns in the cycle after the last step.
  task automatic run_exec(input int c, input int len, input int hold_step, input int hold_n);
    for (int i = 0; i < len; i++) begin
      if (i == hold_step) begin
        hold = 1'b1;
        #1;
        for (int h = 0; h < hold_n; h++) begin
          chk("hold.step", 32'(step), 32'(i));
          chk("hold.step_en", 32'(step_en), 0);
          chk("hold.instr_done", 32'(instr_done), 0);
          tick();
        end
        hold = 1'b0;
        #1;
      end
      chk("exec.cls", 32'(cls), 32'(c));
      chk("exec.step", 32'(step), 32'(i));
      chk("exec.step_en", 32'(step_en), 1);
      chk("exec.instr_done", 32'(instr_done), 32'(i == len - 1));
      tick();
    end
    chk("post.step", 32'(step), 0);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; opcode = '0; qc = '0;
    mem_ready = 1'b0; hold = 1'b0; irq = 1'b0;
    repeat (3) tick();
    all_zero("reset");

    // AD: fetch at cycle 1, steps 0..6 on cycles 4-10, refetch at 11
    reset = 1'b0; run = 1'b1; mem_ready = 1'b1;
    #1;
    chk("idle.fetch_rd", 32'(fetch_rd), 0);
    tick();
    fetch_phase(3'd6, 2'd0, 0);
    run_exec(6, 7, -1, 0);
    chk("ad.ext_flag", 32'(ext_flag), 0);

    // EXTEND with irq raised: entry must be deferred past the extracode
    fetch_phase(3'd5, 2'd1, 0);
    irq = 1'b1;
    run_exec(11, 4, -1, 0);
    chk("ext.ext_flag", 32'(ext_flag), 1);
    chk("ext.irq_ack", 32'(irq_ack), 0);
    chk("ext.step_en", 32'(step_en), 0);

    // MP under extracode, then INTR entry
    fetch_phase(3'd7, 2'd0, 0);
    run_exec(9, 8, -1, 0);
    chk("intr.ext_flag", 32'(ext_flag), 0);
    chk("intr.busy", 32'(busy), 1);
    chk("intr.fetch_rd", 32'(fetch_rd), 0);
    irq = 1'b0;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("intr.cls", 32'(cls), 12);
      chk("intr.step", 32'(step), 32'(i));
      chk("intr.step_en", 32'(step_en), 1);
      chk("intr.irq_ack", 32'(irq_ack), 32'(i == 0));
      chk("intr.instr_done", 32'(instr_done), 0);
      tick();
    end
    hold = 1'b0;

    // Illegal opcode 2 without extracode
    fetch_phase(3'd2, 2'd0, 0);
    chk("ill.trap", 32'(trap), 1);
    chk("ill.cls", 32'(cls), 15);
    chk("ill.step_en", 32'(step_en), 0);

    // EXTEND fetched with 5 cycles of memory wait
    fetch_phase(3'd5, 2'd1, 5);
    chk("ext2.trap", 32'(trap), 0);
    run_exec(11, 4, -1, 0);
    chk("ext2.ext_flag", 32'(ext_flag), 1);

    // DV (20 steps) with hold for 3 cycles at step 5
    fetch_phase(3'd1, 2'd0, 0);
    run_exec(10, 20, 5, 3);
    chk("dv.ext_flag", 32'(ext_flag), 0);

    // INDEX interrupted by reset at step 3
    fetch_phase(3'd5, 2'd0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("idx.step", 32'(step), 32'(i));
      tick();
    end
    chk("idx.step3", 32'(step), 3);
    chk("idx.cls", 32'(cls), 2);
    reset = 1'b1;
    #1;
    all_zero("async_reset");
    tick();
    all_zero("reset_held");
    reset = 1'b0;
    tick();

    // CS with hold on the last step and run dropped mid-instruction
    fetch_phase(3'd4, 2'd0, 0);
    run = 1'b0;
    run_exec(4, 6, 5, 2);
    chk("stop.busy", 32'(busy), 0);
    chk("stop.fetch_rd", 32'(fetch_rd), 0);
    tick();
    chk("idle.busy", 32'(busy), 0);
    chk("idle.fetch_rd2", 32'(fetch_rd), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
